// File: rtl/lzc_pipe_if.sv
// lzc_pipe_if: valid/ready handshake bundle for the pipelined leading-zero counter.
// The master side drives operands and accepts results; the slave side is the counter.
interface lzc_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_cnt;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_cnt, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_cnt, out_zero, out_tag
  );
endinterface

// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined leading-zero counter built as a radix-2 tree of 2-bit leaf
// cells, with one register bank after every tree level (CW stages in total).
// All stages advance together whenever the output slot is empty or being consumed.
// Optional feature macro LZC_APPROX_EN: the low APPROX_LSB operand bits are forced
// to zero before the leaf level, which makes their leaf cells constant.
//
// Partial (p, v) vectors of every level are packed into two flat vectors:
//   level l has WIDTH>>(l+1) nodes, each node has an (l+1)-bit p and a 1-bit v.
//   v of level l starts at WIDTH - (WIDTH>>l); p of level l starts at p_off(l).
//   Node k of a level covers a more significant field than node k-1.
module lzc_pipe #(
  parameter int WIDTH      = 16,
  parameter int TAG_W      = 4,
  parameter int APPROX_LSB = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  lzc_pipe_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

`ifdef LZC_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  // With the feature off the mask keeps every bit, so the count is exact.
  localparam int             MASK_LSB  = APPROX_EN ? APPROX_LSB : 0;
  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << MASK_LSB;

  // Bit offset of the first p field of a tree level inside the flat p vector.
  function automatic int p_off(input int lvl);
    int s;
    s = 0;
    for (int i = 0; i < lvl; i++) begin
      s += (WIDTH >> (i + 1)) * (i + 1);
    end
    return s;
  endfunction

  // Bit offset of the first v flag of a tree level inside the flat v vector.
  function automatic int v_off(input int lvl);
    return WIDTH - (WIDTH >> lvl);
  endfunction

  localparam int P_TOT  = p_off(CW);
  localparam int V_TOT  = WIDTH - 1;
  localparam int ROOT_P = p_off(CW - 1);
  localparam int ROOT_V = v_off(CW - 1);

  logic [WIDTH-1:0]    din_s;
  logic                adv_s;
  logic [P_TOT-1:0]    p_d, p_q;
  logic [V_TOT-1:0]    v_d, v_q;
  logic [CW-1:0]       vld_q;
  logic [CW*TAG_W-1:0] tag_q;

  assign din_s = bus.in_data & KEEP_MASK;

  // Global advance: the pipe moves when the output slot is free or being taken.
  assign adv_s        = ~vld_q[CW-1] | bus.out_ready;
  assign bus.in_ready = adv_s;

  // Tree logic: leaf cells from the operand, merge cells from the previous stage.
  always_comb begin
    p_d = '0;
    v_d = '0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      v_d[k] = din_s[2*k+1] | din_s[2*k];
      p_d[k] = ~din_s[2*k+1];
    end
    for (int l = 1; l < CW; l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        // Left (more significant) child is node 2j+1, right child is node 2j.
        v_d[v_off(l) + j] = v_q[v_off(l-1) + 2*j + 1] | v_q[v_off(l-1) + 2*j];
        for (int b = 0; b < l; b++) begin
          p_d[p_off(l) + j*(l+1) + b] = v_q[v_off(l-1) + 2*j + 1]
                                      ? p_q[p_off(l-1) + (2*j+1)*l + b]
                                      : p_q[p_off(l-1) + 2*j*l + b];
        end
        p_d[p_off(l) + j*(l+1) + l] = ~v_q[v_off(l-1) + 2*j + 1];
      end
    end
  end

  // Stage registers: reset flushes everything, otherwise load on advance or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q   <= '0;
      v_q   <= '0;
      vld_q <= '0;
      tag_q <= '0;
    end else if (adv_s) begin
      p_q   <= p_d;
      v_q   <= v_d;
      vld_q <= {vld_q[CW-2:0], bus.in_valid};
      tag_q <= {tag_q[(CW-1)*TAG_W-1:0], bus.in_tag};
    end else begin
      p_q   <= p_q;
      v_q   <= v_q;
      vld_q <= vld_q;
      tag_q <= tag_q;
    end
  end

  // Root of the tree drives the result; zero is qualified by valid so it reads 0 after reset.
  assign bus.out_valid = vld_q[CW-1];
  assign bus.out_cnt   = p_q[ROOT_P +: CW];
  assign bus.out_zero  = vld_q[CW-1] & ~v_q[ROOT_V];
  assign bus.out_tag   = tag_q[CW*TAG_W-1 -: TAG_W];

endmodule

// File: doc/lzc_pipe.md
# lzc_pipe

Parametrised, pipelined leading-zero counter built as a radix-2 tree of 2-bit aligned leaf cells with one register stage per tree level. It sits in the normalisation path of the approximate floating-point datapath, between the mantissa adder and the normalisation shifter. A valid/ready handshake and a sideband tag let it be dropped into stalling pipelines. A compile-time option masks low-order bits for a cheaper approximate count.

## Interface
- WIDTH, 16: input width; power of two, 4..64.
- TAG_W, 4: sideband tag width carried alongside the data; minimum 1.
- APPROX_LSB, 4: number of low bits masked when LZC_APPROX_EN is defined; 0..WIDTH-2, even. Ignored otherwise.
- CW (localparam) = log2(WIDTH).
- clk  in  1  clock; all flops on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  operand; bit WIDTH-1 is the MSB, counting starts there.
- in_tag  in  TAG_W  opaque sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_cnt  out  CW  leading-zero count.
- out_zero  out  1  no set bit found in the counted field.
- out_tag  out  TAG_W  tag of the word producing this result.

## Operation
- Leaf level: WIDTH/2 cells over bit pairs {b_hi, b_lo} = in_data[2k+1:2k]. p = !b_hi, v = b_hi | b_lo.
- Merge level: combines left (more significant) node L and right node R, each holding (p, v) with p n bits wide. Output v = L.v | R.v. Output p = {1'b0, L.p} if L.v, else {1'b1, R.p}.
- Levels: one leaf level plus CW-1 merge levels, CW levels total. Root p is out_cnt; out_zero = !root v.
- All-zero field: out_zero=1, out_cnt = all ones (WIDTH-1). The tree produces this naturally; no special case is needed.
- Pipeline: one register bank after every level, so there are CW stages. Each stage carries partial (p, v) vectors, the tag, and a valid bit.
- Flow control is a global advance: adv = !out_valid | out_ready; in_ready = adv.
- On adv, every stage loads from its predecessor. Stage 0 loads the leaf outputs, with valid = in_valid. Bubbles propagate as valid=0 stages and are not collapsed.
- When adv=0 all stage registers, including data, hold.
- Reset: all stage valid bits are cleared, all data and tag registers are cleared to 0, and any in-flight words are discarded. After reset, out_valid=0, out_cnt=0, out_zero=0, out_tag=0, and in_ready=1.

## Timing
- Latency: a word accepted at edge N (in_valid & in_ready) appears on out_valid/out_cnt at edge N+CW when there are no stalls. For WIDTH=16 this is 4 cycles.
- Throughput: one word per cycle while out_ready=1.
- A stall of S cycles (out_valid=1, out_ready=0) delays every in-flight word by exactly S cycles.
- While out_valid=1 and out_ready=0, out_cnt, out_zero and out_tag stay stable.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from in_data to any output.
- Simultaneous in_valid and out_ready with a full pipeline: the output is consumed and the input is accepted in the same edge.
- rst_n=0 takes priority over adv on the same edge.

## Configuration
- LZC_APPROX_EN defined: in_data[APPROX_LSB-1:0] is forced to 0 before the leaf level, and the corresponding leaf cells are removed.
  - A leading one lying only in the masked bits yields out_zero=1, out_cnt=WIDTH-1.
  - Counts for a leading one at or above bit APPROX_LSB are exact.
  - Latency is unchanged.
- LZC_APPROX_EN undefined: the count is exact over all WIDTH bits and APPROX_LSB has no effect.

## Test plan
All scenarios use WIDTH=16 and TAG_W=4.
- Exact counts: with out_ready held at 1, send 0x8000/tag 1, 0x0010/tag 2, 0x0001/tag 3, 0x0000/tag 4 on consecutive cycles. Required: results on cycles 4..7 of cnt 0/zero 0, 11/0, 15/0, 15/1, with tags 1..4 in order.
- Exhaustive: all 65536 inputs streamed back-to-back. Required: every out_cnt matches the reference clz and out_zero is set only for input 0.
- Backpressure: out_ready driven with a random 50% pattern. Required: no loss or duplication, tag order preserved, outputs stable while stalled, in_ready=0 exactly when out_valid=1 and out_ready=0.
- Bubbles: in_valid pattern 1,0,1,0. Required: out_valid shows the same pattern delayed by 4 cycles.
- Reset mid-flight: 3 words in the pipe, then rst_n=0 for one edge. Required: out_valid=0 and all outputs 0 from the next cycle, in_ready=1, and none of the flushed words ever appear.
- Approximate build (LZC_APPROX_EN, APPROX_LSB=4): 0x000F gives zero=1, cnt 15; 0x0010 gives cnt 11; 0x0100 gives cnt 7.
